input_frame_loader: RTL and testbench
=====================================

# input_frame_loader

Upstream stage of the neuron array. Accepts an 8-bit pixel stream over a valid/ready handshake, converts each pixel to 16-bit signed fixed point, and assembles a full frame of INPUT_SIZE words. When the frame is complete it pulses `start` to the hidden layer and holds the vector stable until the layer reports completion. It then reopens for the next frame.

## Interface
- `INPUT_SIZE`, 784: pixels per frame; width of `input_vector`.
- `ADDR_WIDTH`, 10: write-pointer width; must satisfy 2^ADDR_WIDTH >= INPUT_SIZE.
- `PIXEL_SHIFT`, 7: left shift applied to each pixel to form the fixed-point value.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  pixel-stream valid.
- `in_ready`  out  1  loader can accept a pixel.
- `in_pixel`  in  8  unsigned pixel value.
- `in_last`  in  1  marks the final pixel of a frame. Only used when `LOADER_TLAST_CHECK_EN` is defined.
- `input_vector`  out  16 signed x INPUT_SIZE (unpacked)  frame buffer driven to the neuron inputs.
- `start`  out  1  one-cycle pulse; the frame is ready.
- `layer_done`  in  1  the consuming layer has finished with the frame.
- `busy`  out  1  high in FIRE and WAIT.
- `frame_err`  out  1  one-cycle pulse; a frame was discarded.
- `frame_count`  out  16  number of frames consumed by the layer.

## Operation
The loader is a three-state FSM: FILL, FIRE, WAIT. It resets to FILL.

FILL:
- `in_ready` = 1.
- A pixel is accepted when `in_valid && in_ready`.
- The pixel is written to `buf[wr_ptr]` and `wr_ptr` increments.
- Stored value = zero-extended pixel << PIXEL_SHIFT, saturated to 16'sh7FFF. The result is never negative.
- Acceptance of index INPUT_SIZE-1 sets `wr_ptr` to 0 and moves to FIRE.

FIRE:
- `in_ready` = 0 and `start` = 1 for exactly this one cycle.
- Next state is WAIT.

WAIT:
- `in_ready` = 0; the buffer is frozen.
- On `layer_done` = 1, move to FILL and increment `frame_count`, which wraps from 0xFFFF to 0.

General rules:
- `layer_done` is ignored in FILL and FIRE.
- `input_vector[i]` = `buf[i]` at all times. Words are overwritten in place during FILL, so the consumer must not sample outside FIRE/WAIT.
- `busy` = (state != FILL).

## Timing
- Reset values: `in_ready` 0 while `rst_n` is low, then 1 in the first cycle after release. `start` 0, `busy` 0, `frame_err` 0, `frame_count` 0, `wr_ptr` 0, all buffer words 0, state FILL.
- Throughput in FILL is one pixel per cycle with no bubbles.
- `start` is high in the cycle immediately after the last pixel is accepted.
- The earliest re-acceptance of pixels is the cycle after `layer_done` is sampled in WAIT.
- Minimum frame period is INPUT_SIZE + 2 + (layer latency) cycles.
- Reset asserted mid-frame or in WAIT aborts immediately. The partial frame is lost and no `start` is issued.
- `in_valid` low stalls the pointer; the frame resumes with no loss.

## Configuration
Macro: `LOADER_TLAST_CHECK_EN`.

With the macro defined:
- `in_last` is checked on every accepted pixel.
- Error case A: `in_last` = 1 on an index below INPUT_SIZE-1.
- Error case B: `in_last` = 0 on index INPUT_SIZE-1.
- On either error: pulse `frame_err` in the next cycle, reset `wr_ptr` to 0, stay in FILL, and issue no `start`. The erroneous pixel is written but the frame is discarded.

Without the macro:
- `in_last` is ignored and framing is by count only.
- `frame_err` is tied to 0.

## Test plan
- Reset, then stream 784 pixels, pixel[i] = i mod 256, `in_valid` held high -> `in_ready` drops after pixel 783; `start` pulses one cycle later; `input_vector[5]` = 16'd640 and `input_vector[255]` = 16'd32640.
- PIXEL_SHIFT = 8 with pixel 255 -> stored value 16'sh7FFF (saturated); pixel 1 -> 16'd256.
- In WAIT, drive `in_valid` for 50 cycles, then `layer_done` -> no pixels accepted and the buffer is unchanged; `frame_count` becomes 1 and `in_ready` = 1 the next cycle.
- Random `in_valid` gaps over a frame -> `start` fires exactly once, after the 784th accepted pixel, with the buffer equal to the reference model.
- With `LOADER_TLAST_CHECK_EN` defined, `in_last` on pixel 100 -> `frame_err` pulses once, no `start`; the next 784 pixels with a correct `in_last` produce a normal `start`.
- `rst_n` pulsed low at pixel 400 -> all outputs return to reset values; the following full frame loads from index 0 and produces `start`.

Source files
------------

// File: rtl/input_frame_loader_if.sv
// Pixel-stream handshake between an upstream source and the frame loader.
// One beat per cycle when in_valid and in_ready are both high; in_last tags the final pixel.
interface input_frame_loader_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_pixel;
    logic       in_last;

    modport master (output in_valid, output in_pixel, output in_last, input in_ready);
    modport slave  (input in_valid, input in_pixel, input in_last, output in_ready);
endinterface

// File: rtl/input_frame_loader.sv
// Frame loader: packs 8-bit pixels into INPUT_SIZE signed 16-bit words, pulses start, holds until layer_done.
// Latency: start rises the cycle after the last pixel is accepted; one pixel per cycle while filling.
// Backpressure: in_ready low from the last pixel until layer_done; LOADER_TLAST_CHECK_EN enables in_last framing checks.
module input_frame_loader #(
    parameter int INPUT_SIZE  = 784,
    parameter int ADDR_WIDTH  = 10,
    parameter int PIXEL_SHIFT = 7
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input_frame_loader_if.slave      px,
    output logic signed [15:0]       input_vector [INPUT_SIZE],
    output logic                     start,
    input  logic                     layer_done,
    output logic                     busy,
    output logic                     frame_err,
    output logic [15:0]              frame_count
);
    typedef enum logic [1:0] {FILL, FIRE, WAIT} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(INPUT_SIZE - 1);

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  wr_ptr;
    logic                   ready_q;
    logic                   start_q;
    logic                   busy_q;
    logic                   err_q;
    logic [15:0]            count_q;
    logic signed [15:0]     frame_buf [INPUT_SIZE];

    logic [31:0]            shifted;
    logic signed [15:0]     pixel_fx;
    logic                   accept;
    logic                   at_last;
    logic                   framing_err;

    // Pixel is unsigned, so the only overflow direction is positive.
    assign shifted  = 32'(px.in_pixel) << PIXEL_SHIFT;
    assign pixel_fx = (shifted > 32'h0000_7FFF) ? 16'sh7FFF : signed'(shifted[15:0]);

    assign accept  = px.in_valid && ready_q;
    assign at_last = (wr_ptr == LAST_IDX);

`ifdef LOADER_TLAST_CHECK_EN
    assign framing_err = accept && (px.in_last != at_last);
`else
    logic unused_last;
    assign unused_last = px.in_last;
    assign framing_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FILL;
            wr_ptr  <= '0;
            ready_q <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            start_q <= 1'b0;
            err_q   <= 1'b0;
            unique case (state)
                FILL: begin
                    ready_q <= 1'b1;
                    if (framing_err) begin
                        // Discard the partial frame; the offending pixel is still written.
                        wr_ptr <= '0;
                        err_q  <= 1'b1;
                    end else if (accept && at_last) begin
                        wr_ptr  <= '0;
                        ready_q <= 1'b0;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state   <= FIRE;
                    end else if (accept) begin
                        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
                    end
                end
                FIRE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (layer_done) begin
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        count_q <= count_q + 16'd1;
                        state   <= FILL;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < INPUT_SIZE; i++) begin
                frame_buf[i] <= '0;
            end
        end else if (accept) begin
            frame_buf[wr_ptr] <= pixel_fx;
        end
    end

    assign input_vector = frame_buf;
    assign start        = start_q;
    assign busy         = busy_q;
    assign frame_err    = err_q;
    assign frame_count  = count_q;
    assign px.in_ready  = ready_q;
endmodule

// File: tb/tb_input_frame_loader.sv
// Scoreboarded bench for input_frame_loader: random pixel streams against a frame-level reference model.
module tb_input_frame_loader;
    localparam int N  = 784;
    localparam int SH = 7;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    input_frame_loader_if pif ();
    input_frame_loader_if pif2 ();

    logic signed [15:0] vec  [N];
    logic signed [15:0] vec2 [4];
    logic        start, busy, frame_err, layer_done;
    logic [15:0] frame_count;
    logic        start2, busy2, frame_err2, layer_done2;
    logic [15:0] frame_count2;

    input_frame_loader #(.INPUT_SIZE(N), .ADDR_WIDTH(10), .PIXEL_SHIFT(SH)) dut (
        .clk(clk), .rst_n(rst_n), .px(pif.slave), .input_vector(vec), .start(start),
        .layer_done(layer_done), .busy(busy), .frame_err(frame_err), .frame_count(frame_count)
    );

    input_frame_loader #(.INPUT_SIZE(4), .ADDR_WIDTH(2), .PIXEL_SHIFT(8)) dut_sat (
        .clk(clk), .rst_n(rst_n), .px(pif2.slave), .input_vector(vec2), .start(start2),
        .layer_done(layer_done2), .busy(busy2), .frame_err(frame_err2), .frame_count(frame_count2)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state: position in the current frame and the words gathered so far.
    int          acc_idx = 0;
    int          cur [N];
    int          last_frame [N];
    int          exp_count = 0;
    logic [15:0] exp_words[$];
    int          exp_start_cyc[$];
    int          exp_err_cyc[$];

    function automatic int sat(input int p, input int sh);
        int v;
        v = p << sh;
        return (v > 32767) ? 32767 : v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string nm);
        int bad = 0;
        for (int i = 0; i < N; i++) if (vec[i] !== 16'sd0) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL %s: %0d nonzero buffer words, expected 0", nm, bad);
        end
    endtask

    task automatic chk_frozen(input string nm);
        int bad = 0;
        for (int i = 0; i < N; i++) if (vec[i] !== 16'(last_frame[i])) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL %s: %0d buffer words changed, expected 0", nm, bad);
        end
    endtask

    task automatic model_accept(input int p, input logic last);
        logic is_end;
        cur[acc_idx] = sat(p, SH);
        is_end = (acc_idx == N - 1);
`ifdef LOADER_TLAST_CHECK_EN
        if (last != is_end) begin
            exp_err_cyc.push_back(cyc + 1);
            acc_idx = 0;
            return;
        end
`endif
        if (is_end) begin
            for (int i = 0; i < N; i++) begin
                exp_words.push_back(16'(cur[i]));
                last_frame[i] = cur[i];
            end
            exp_start_cyc.push_back(cyc + 1);
            acc_idx = 0;
        end else begin
            acc_idx++;
        end
    endtask

    // mode 0: pixel = frame index mod 256; mode 1: random. bad_at flips in_last on that beat.
    task automatic send(input int n, input int mode, input int gap_pct, input int bad_at);
        int   sent = 0;
        int   budget = 0;
        int   p;
        logic lst;
        while (sent < n) begin
            @(negedge clk);
            budget++;
            if (budget > 20 * n + 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL send_timeout: accepted %0d of %0d pixels", sent, n);
                pif.in_valid = 1'b0;
                return;
            end
            if (int'($urandom_range(99)) < gap_pct) begin
                pif.in_valid = 1'b0;
                pif.in_last  = 1'($urandom_range(1));
            end else begin
                p   = (mode == 0) ? (acc_idx % 256) : int'($urandom_range(255));
                lst = ((acc_idx == N - 1) != (sent == bad_at));
                pif.in_valid = 1'b1;
                pif.in_pixel = 8'(p);
                pif.in_last  = lst;
                if (pif.in_ready) begin
                    model_accept(p, lst);
                    sent++;
                end
            end
        end
    endtask

    task automatic finish_layer(input int d);
        repeat (d) @(negedge clk);
        layer_done = 1'b1;
        @(negedge clk);
        layer_done = 1'b0;
        exp_count++;
        chk("frame_count", 32'(frame_count), 32'(exp_count & 16'hFFFF));
        chk("ready_reopen", 32'(pif.in_ready), 32'd1);
        chk("busy_clear", 32'(busy), 32'd0);
    endtask

    // Monitor: every start pops one expected frame and its expected cycle.
    int          mon_ec, mon_bad, mon_first;
    logic [15:0] mon_w;
    always @(negedge clk) begin
        if (rst_n && start) begin
            n_cmp++;
            if (exp_start_cyc.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_start: start=1 at cycle %0d, expected no start", cyc);
            end else begin
                mon_ec    = exp_start_cyc.pop_front();
                mon_bad   = 0;
                mon_first = -1;
                for (int i = 0; i < N; i++) begin
                    mon_w = exp_words.pop_front();
                    if (vec[i] !== mon_w) begin
                        mon_bad++;
                        if (mon_first < 0) mon_first = i;
                    end
                end
                if (mon_ec != cyc || mon_bad != 0) begin
                    n_bad++;
                    $display("FAIL frame_check: start at cycle %0d expected %0d; %0d bad words (first idx %0d)",
                             cyc, mon_ec, mon_bad, mon_first);
                end
            end
        end
        if (rst_n && frame_err) begin
            n_cmp++;
            if (exp_err_cyc.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_frame_err: frame_err=1 at cycle %0d, expected 0", cyc);
            end else begin
                mon_ec = exp_err_cyc.pop_front();
                if (mon_ec != cyc) begin
                    n_bad++;
                    $display("FAIL frame_err_timing: at cycle %0d, expected %0d", cyc, mon_ec);
                end
            end
        end
    end

    int rdy_hi;
    int sv [4] = '{255, 1, 0, 128};

    initial begin
        pif.in_valid  = 1'b0; pif.in_pixel  = 8'd0; pif.in_last  = 1'b0;
        pif2.in_valid = 1'b0; pif2.in_pixel = 8'd0; pif2.in_last = 1'b0;
        layer_done = 1'b0; layer_done2 = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(pif.in_ready), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        chk_zero("rst_buffer");
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(pif.in_ready), 32'd1);

        layer_done = 1'b1;
        @(negedge clk);
        layer_done = 1'b0;
        chk("done_in_fill_ignored", 32'(frame_count), 32'd0);

        // Saturation on a small instance with shift 8.
        for (int i = 0; i < 4; i++) begin
            pif2.in_valid = 1'b1;
            pif2.in_pixel = 8'(sv[i]);
            pif2.in_last  = (i == 3);
            @(negedge clk);
        end
        pif2.in_valid = 1'b0;
        chk("sat_start", 32'(start2), 32'd1);
        for (int i = 0; i < 4; i++) chk($sformatf("sat_word%0d", i), 32'(vec2[i]), 32'(sat(sv[i], 8)));

        // Full frame with an index ramp and valid held high.
        send(N, 0, 0, -1);
        @(negedge clk);
        chk("ready_drop", 32'(pif.in_ready), 32'd0);
        chk("start_pulse", 32'(start), 32'd1);
        @(negedge clk);
        chk("start_one_cycle", 32'(start), 32'd0);
        chk("busy_wait", 32'(busy), 32'd1);
        chk("vec5", 32'(vec[5]), 32'd640);
        chk("vec255", 32'(vec[255]), 32'd32640);
        chk("vec256", 32'(vec[256]), 32'd0);

        // Valid asserted throughout WAIT must not be accepted.
        pif.in_valid = 1'b1;
        pif.in_pixel = 8'hAA;
        rdy_hi = 0;
        repeat (50) begin
            @(negedge clk);
            if (pif.in_ready) rdy_hi++;
        end
        chk("wait_no_accept", 32'(rdy_hi), 32'd0);
        chk_frozen("wait_frozen");
        pif.in_valid = 1'b0;
        finish_layer(0);

        // Random pixels with valid gaps; layer_done in FIRE is ignored.
        send(N, 1, 30, -1);
        @(negedge clk);
        pif.in_valid = 1'b0;
        layer_done = 1'b1;
        @(negedge clk);
        layer_done = 1'b0;
        chk("done_in_fire_ignored", 32'(frame_count), 32'(exp_count));
        chk("busy_after_fire", 32'(busy), 32'd1);
        finish_layer(5);

`ifdef LOADER_TLAST_CHECK_EN
        // Early in_last at pixel 100, then a correct frame.
        send(101 + N, 1, 0, 100);
        @(negedge clk);
        pif.in_valid = 1'b0;
        finish_layer(2);
        // Missing in_last on the final index, then a correct frame.
        send(N, 1, 0, N - 1);
        send(N, 1, 10, -1);
        @(negedge clk);
        pif.in_valid = 1'b0;
        finish_layer(2);
`else
        // in_last garbage is ignored when framing is by count.
        send(N, 1, 0, 100);
        @(negedge clk);
        pif.in_valid = 1'b0;
        finish_layer(2);
`endif

        // Reset in the middle of a frame.
        send(400, 1, 20, -1);
        @(negedge clk);
        rst_n = 1'b0;
        pif.in_valid = 1'b0;
        acc_idx = 0;
        exp_count = 0;
        #1;
        chk("midrst_in_ready", 32'(pif.in_ready), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_frame_count", 32'(frame_count), 32'd0);
        chk_zero("midrst_buffer");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(N, 1, 10, -1);
        @(negedge clk);
        pif.in_valid = 1'b0;
        finish_layer(3);

        repeat (3) @(negedge clk);
        chk("starts_drained", 32'(exp_start_cyc.size()), 32'd0);
        chk("errs_drained", 32'(exp_err_cyc.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
